pe_dot_sequencer: RTL and testbench
===================================

# pe_dot_sequencer

Initiator and result collector for the `vec_mul` processing element. The block accepts a dot-product command of `cmd_len` C-lane chunks and streams the matching `x`/`k` operand chunks into the PE one chunk per `pe_enable` pulse. It sums the PE partial results into one full-precision accumulator and returns the final dot product on a valid/ready result port. It sits between the vector register/operand buffers and the PE array in the SoC datapath.

## Interface
Parameters:
- `C`, 4, lanes per chunk; must match the attached PE.
- `W_X`, 8, signed x-lane width.
- `W_K`, 8, signed k-lane width.
- `W_Y`, `W_X+W_K+$clog2(C)`, signed PE result width.
- `MAX_CHUNKS`, 16, maximum chunks per command.
- `W_O`, `W_Y`, signed output width; the internal accumulator is `W_ACC = W_Y+$clog2(MAX_CHUNKS)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_len`  in  `$clog2(MAX_CHUNKS+1)`  number of chunks, 0..MAX_CHUNKS.
- `s_valid`  in  1  operand chunk offered.
- `s_ready`  out  1  high in STREAM while `issue_cnt < len`.
- `s_x`  in  `[C-1:0][W_X-1:0]` signed  x chunk.
- `s_k`  in  `[C-1:0][W_K-1:0]` signed  k chunk.
- `pe_enable`  out  1  one-cycle issue pulse to the PE.
- `pe_x`  out  `[C-1:0][W_X-1:0]`  registered x chunk to the PE.
- `pe_k`  out  `[C-1:0][W_K-1:0]`  registered k chunk to the PE.
- `pe_y`  in  `W_Y` signed  PE result.
- `pe_valid`  in  1  PE result valid.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result accepted.
- `m_data`  out  `W_O` signed  dot product.
- `m_sat`  out  1  result was clamped.
- `err`  out  1  sticky protocol error.

## Operation
- FSM states: IDLE, STREAM, DRAIN, OUT.
- IDLE:
  - A command fires on `cmd_valid & cmd_ready`.
  - On fire: latch `len`, clear `acc`, `issue_cnt` and `recv_cnt`.
  - If `len==0`, go to OUT with result 0. Otherwise go to STREAM.
- STREAM:
  - Each `s_valid & s_ready` fire registers `s_x`/`s_k` into `pe_x`/`pe_k`, pulses `pe_enable` in the next cycle, and increments `issue_cnt`.
  - When the last chunk is issued, go to DRAIN.
- STREAM and DRAIN:
  - Each `pe_valid` adds sign-extended `pe_y` to `acc` and increments `recv_cnt`.
  - The block counts results; it does not assume a fixed PE latency.
  - When `recv_cnt` reaches `len`, go to OUT.
- OUT:
  - `m_valid=1`; `m_data` and `m_sat` stay stable until `m_ready`.
  - On the `m_valid & m_ready` fire, go to IDLE.
- `pe_x`/`pe_k` hold their last value when no chunk is issued.
- `cmd_valid` is ignored outside IDLE. `s_valid` is ignored when `s_ready=0`.
- `pe_valid` in IDLE or OUT sets `err`. The sample is discarded and `err` clears only on `rst`.
- Reset values: state=IDLE, `cmd_ready=1`, `s_ready=0`, `pe_enable=0`, `pe_x=0`, `pe_k=0`, `m_valid=0`, `m_data=0`, `m_sat=0`, `err=0`, all counters 0.
- Reset mid-operation abandons the command. The PE shares `rst`, so no stale results arrive afterwards.

## Timing
- An `s` fire at edge t gives `pe_enable=1` in cycle t+1, for exactly one cycle.
- The PE returns `pe_valid` `$clog2(C)+1` cycles later.
- The edge that accepts the final `pe_valid` moves the FSM to OUT; `m_valid` rises in the next cycle.
- A single-chunk command takes 3+`$clog2(C)` cycles from command fire to `m_valid`.
- A command with `len==0` gives `m_valid` the cycle after command fire.
- `s` fires and `pe_valid` may occur in the same cycle; both take effect.
- `m` fire at edge t gives `cmd_ready=1` in cycle t+1.
- Throughput is one chunk per cycle.

## Configuration
- `PE_SEQ_SAT_EN` defined:
  - When `acc` falls outside the signed `W_O` range, `m_data` clamps to `2^(W_O-1)-1` or `-2^(W_O-1)`.
  - `m_sat=1` when the clamp occurs.
- `PE_SEQ_SAT_EN` undefined:
  - `m_data` is the low `W_O` bits of `acc` (two's-complement wrap).
  - `m_sat` is tied to 0.

## Test plan
- Single chunk: `len=1`, `s_x=32'h03020107`, `s_k=32'h01030309` -> one `pe_enable` pulse, `m_data=75`, `m_sat=0`.
- Multiple chunks: `len=3`, the same chunk three times with `s_valid` toggled every other cycle -> exactly 3 `pe_enable` pulses, `m_data=225`.
- Empty command: `len=0` -> no `pe_enable`, `m_valid` one cycle after command fire, `m_data=0`.
- Overflow at defaults (`W_O=18`): `len=2`, all lanes x=k=-128 -> with `PE_SEQ_SAT_EN`, `m_data=131071` and `m_sat=1`; without it, `m_data=-131072` and `m_sat=0`.
- Backpressure: hold `m_ready=0` for 5 cycles in OUT -> `m_data` stable, `cmd_ready=0`; after the fire, `cmd_ready=1` in the next cycle.
- Errors and reset: `pe_valid=1` while in IDLE -> `err=1` and held. Assert `rst` mid-STREAM -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/pe_dot_sequencer.sv
// Dot-product command sequencer for the vec_mul PE: streams operand chunks, sums PE partials, returns the result.
// Optional output clamping is enabled by defining PE_SEQ_SAT_EN; otherwise the result wraps.
module pe_dot_sequencer #(
    parameter int C          = 4,
    parameter int W_X        = 8,
    parameter int W_K        = 8,
    parameter int W_Y        = W_X + W_K + $clog2(C),
    parameter int MAX_CHUNKS = 16,
    parameter int W_O        = W_Y
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [$clog2(MAX_CHUNKS+1)-1:0] cmd_len,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [C-1:0][W_X-1:0]           s_x,
    input  logic [C-1:0][W_K-1:0]           s_k,
    output logic                            pe_enable,
    output logic [C-1:0][W_X-1:0]           pe_x,
    output logic [C-1:0][W_K-1:0]           pe_k,
    input  logic signed [W_Y-1:0]           pe_y,
    input  logic                            pe_valid,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic signed [W_O-1:0]           m_data,
    output logic                            m_sat,
    output logic                            err
);

    localparam int W_LEN = $clog2(MAX_CHUNKS + 1);
    localparam int W_ACC = W_Y + $clog2(MAX_CHUNKS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t                   state_reg, state_next;
    logic [W_LEN-1:0]         len_reg, len_next;
    logic [W_LEN-1:0]         issue_cnt_reg, issue_cnt_next;
    logic [W_LEN-1:0]         recv_cnt_reg, recv_cnt_next;
    logic signed [W_ACC-1:0]  acc_reg, acc_next;
    logic [C-1:0][W_X-1:0]    pe_x_reg, pe_x_next;
    logic [C-1:0][W_K-1:0]    pe_k_reg, pe_k_next;
    logic                     pe_enable_reg, pe_enable_next;
    logic signed [W_O-1:0]    m_data_reg, m_data_next;
    logic                     m_sat_reg, m_sat_next;
    logic                     err_reg, err_next;

    logic                     cmd_fire;
    logic                     s_fire;
    logic                     last_result;
    logic signed [W_ACC-1:0]  acc_sum;
    logic signed [W_O-1:0]    res_data;
    logic                     res_sat;

    assign cmd_ready = (state_reg == IDLE);
    assign s_ready   = (state_reg == STREAM) && (issue_cnt_reg < len_reg);
    assign m_valid   = (state_reg == OUT);
    assign pe_enable = pe_enable_reg;
    assign pe_x      = pe_x_reg;
    assign pe_k      = pe_k_reg;
    assign m_data    = m_data_reg;
    assign m_sat     = m_sat_reg;
    assign err       = err_reg;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign s_fire      = s_valid && s_ready;
    assign last_result = pe_valid && (W_LEN'(recv_cnt_reg + 1'b1) == len_reg);

    // Running sum including the partial arriving this cycle; on the last result this is the final value.
    assign acc_sum = acc_reg + W_ACC'(pe_y);

`ifdef PE_SEQ_SAT_EN
    generate
        if (W_O < W_ACC) begin : g_clamp
            logic [W_ACC-W_O:0] top_bits;
            // The value fits when every bit above the output sign bit equals it.
            assign top_bits = acc_sum[W_ACC-1:W_O-1];
            assign res_sat  = !((&top_bits) || !(|top_bits));
            assign res_data = !res_sat        ? acc_sum[W_O-1:0] :
                              acc_sum[W_ACC-1] ? {1'b1, {(W_O-1){1'b0}}} :
                                                 {1'b0, {(W_O-1){1'b1}}};
        end else begin : g_no_clamp
            assign res_data = W_O'(acc_sum);
            assign res_sat  = 1'b0;
        end
    endgenerate
`else
    logic unused_acc_bits;
    assign unused_acc_bits = ^acc_sum;
    assign res_data        = W_O'(acc_sum);
    assign res_sat         = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        issue_cnt_next = issue_cnt_reg;
        recv_cnt_next  = recv_cnt_reg;
        acc_next       = acc_reg;
        pe_x_next      = pe_x_reg;
        pe_k_next      = pe_k_reg;
        pe_enable_next = 1'b0;
        m_data_next    = m_data_reg;
        m_sat_next     = m_sat_reg;
        err_next       = err_reg;

        unique case (state_reg)
            IDLE: begin
                if (pe_valid) begin
                    err_next = 1'b1;
                end
                if (cmd_fire) begin
                    len_next       = cmd_len;
                    acc_next       = '0;
                    issue_cnt_next = '0;
                    recv_cnt_next  = '0;
                    if (cmd_len == '0) begin
                        state_next  = OUT;
                        m_data_next = '0;
                        m_sat_next  = 1'b0;
                    end else begin
                        state_next = STREAM;
                    end
                end
            end

            STREAM, DRAIN: begin
                if (s_fire) begin
                    pe_x_next      = s_x;
                    pe_k_next      = s_k;
                    pe_enable_next = 1'b1;
                    issue_cnt_next = W_LEN'(issue_cnt_reg + 1'b1);
                end
                if (pe_valid) begin
                    acc_next      = acc_sum;
                    recv_cnt_next = W_LEN'(recv_cnt_reg + 1'b1);
                end
                // Results never outrun issues, so the last result always lands in DRAIN.
                if (last_result) begin
                    state_next  = OUT;
                    m_data_next = res_data;
                    m_sat_next  = res_sat;
                end else if ((state_reg == STREAM) && (issue_cnt_next == len_reg)) begin
                    state_next = DRAIN;
                end
            end

            OUT: begin
                if (pe_valid) begin
                    err_next = 1'b1;
                end
                if (m_ready) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            issue_cnt_reg <= '0;
            recv_cnt_reg  <= '0;
            acc_reg       <= '0;
            pe_x_reg      <= '0;
            pe_k_reg      <= '0;
            pe_enable_reg <= 1'b0;
            m_data_reg    <= '0;
            m_sat_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            issue_cnt_reg <= issue_cnt_next;
            recv_cnt_reg  <= recv_cnt_next;
            acc_reg       <= acc_next;
            pe_x_reg      <= pe_x_next;
            pe_k_reg      <= pe_k_next;
            pe_enable_reg <= pe_enable_next;
            m_data_reg    <= m_data_next;
            m_sat_reg     <= m_sat_next;
            err_reg       <= err_next;
        end
    end

endmodule

// File: tb/tb_pe_dot_sequencer.sv
// Self-checking bench for pe_dot_sequencer with a fixed-latency behavioural PE and a result scoreboard.
module tb_pe_dot_sequencer;

    localparam int C          = 4;
    localparam int W_X        = 8;
    localparam int W_K        = 8;
    localparam int W_Y        = W_X + W_K + $clog2(C);
    localparam int MAX_CHUNKS = 16;
    localparam int W_O        = W_Y;
    localparam int W_LEN      = $clog2(MAX_CHUNKS + 1);
    localparam int PE_LAT     = $clog2(C) + 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [W_LEN-1:0]         cmd_len;
    logic                     s_valid;
    logic                     s_ready;
    logic [C-1:0][W_X-1:0]    s_x;
    logic [C-1:0][W_K-1:0]    s_k;
    logic                     pe_enable;
    logic [C-1:0][W_X-1:0]    pe_x;
    logic [C-1:0][W_K-1:0]    pe_k;
    logic signed [W_Y-1:0]    pe_y;
    logic                     pe_valid;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [W_O-1:0]    m_data;
    logic                     m_sat;
    logic                     err;

    logic                     pe_inj;
    int                       n_checks = 0;
    int                       n_errors = 0;
    int                       cyc = 0;
    int                       en_cnt = 0;

    typedef struct {
        logic signed [W_O-1:0] data;
        logic                  sat;
    } exp_t;

    exp_t exp_q[$];

    pe_dot_sequencer #(
        .C(C), .W_X(W_X), .W_K(W_K), .W_Y(W_Y), .MAX_CHUNKS(MAX_CHUNKS), .W_O(W_O)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_k(s_k),
        .pe_enable(pe_enable), .pe_x(pe_x), .pe_k(pe_k),
        .pe_y(pe_y), .pe_valid(pe_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pe_enable) en_cnt <= en_cnt + 1;
    end

    function automatic longint pe_dot(input logic [C-1:0][W_X-1:0] x, input logic [C-1:0][W_K-1:0] k);
        longint s = 0;
        for (int i = 0; i < C; i++) s += longint'($signed(x[i])) * longint'($signed(k[i]));
        return s;
    endfunction

    // Behavioural PE: result appears PE_LAT cycles after the pe_enable cycle.
    logic [PE_LAT-1:0]     v_pipe;
    logic signed [W_Y-1:0] y_pipe [PE_LAT];
    logic signed [W_Y-1:0] dot_now;
    assign dot_now  = W_Y'(pe_dot(pe_x, pe_k));
    assign pe_valid = v_pipe[PE_LAT-1] | pe_inj;
    assign pe_y     = y_pipe[PE_LAT-1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            v_pipe <= '0;
            for (int i = 0; i < PE_LAT; i++) y_pipe[i] <= '0;
        end else begin
            v_pipe[0] <= pe_enable;
            y_pipe[0] <= dot_now;
            for (int i = 1; i < PE_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                y_pipe[i] <= y_pipe[i-1];
            end
        end
    end

    function automatic exp_t model(input longint sum);
        exp_t   e;
        longint maxv = (longint'(1) <<< (W_O - 1)) - 1;
        longint minv = -maxv - 1;
`ifdef PE_SEQ_SAT_EN
        if (sum > maxv) begin
            e.data = W_O'(maxv); e.sat = 1'b1;
        end else if (sum < minv) begin
            e.data = W_O'(minv); e.sat = 1'b1;
        end else begin
            e.data = W_O'(sum);  e.sat = 1'b0;
        end
`else
        e.data = W_O'(sum);
        e.sat  = 1'b0;
`endif
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input int len, input bit rnd,
                           input logic [C-1:0][W_X-1:0] fx, input logic [C-1:0][W_K-1:0] fk,
                           input bit toggle, input int hold, input int exp_lat);
        logic [C-1:0][W_X-1:0] xs [MAX_CHUNKS];
        logic [C-1:0][W_K-1:0] ks [MAX_CHUNKS];
        longint                sum = 0;
        exp_t                  e;
        int                    issued, guard, en0, f_cyc;
        bit                    phase, fire;
        logic signed [W_O-1:0] held;

        for (int c = 0; c < len; c++) begin
            for (int i = 0; i < C; i++) begin
                xs[c][i] = rnd ? W_X'($urandom) : fx[i];
                ks[c][i] = rnd ? W_K'($urandom) : fk[i];
            end
            sum += pe_dot(xs[c], ks[c]);
        end
        exp_q.push_back(model(sum));
        m_ready = (hold == 0);

        guard = 0;
        while (!cmd_ready && guard < 50) begin tick(); guard++; end
        check_eq("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len   = W_LEN'(len);
        en0       = en_cnt;
        tick();
        cmd_valid = 1'b0;
        f_cyc     = cyc;

        issued = 0; phase = 1'b1; guard = 0;
        while (issued < len && guard < 200) begin
            s_x     = xs[issued];
            s_k     = ks[issued];
            s_valid = toggle ? phase : 1'b1;
            fire    = s_valid && s_ready;
            tick();
            if (fire) issued++;
            phase = ~phase;
            guard++;
        end
        s_valid = 1'b0;
        check_eq("chunks_issued", issued, len);

        guard = 0;
        while (!m_valid && guard < 100) begin tick(); guard++; end
        check_eq("m_valid_seen", m_valid, 1);
        if (exp_lat >= 0) check_eq("latency", cyc - f_cyc, exp_lat);
        check_eq("pe_enable_pulses", en_cnt - en0, len);

        check_eq("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("m_data", m_data, e.data);
            check_eq("m_sat", m_sat, e.sat);
        end

        held = m_data;
        for (int h = 0; h < hold; h++) begin
            tick();
            check_eq("bp_m_data_stable", m_data, held);
            check_eq("bp_cmd_ready_low", cmd_ready, 0);
            check_eq("bp_m_valid_high", m_valid, 1);
        end
        m_ready = 1'b1;
        tick();
        check_eq("cmd_ready_after_fire", cmd_ready, 1);
        check_eq("m_valid_after_fire", m_valid, 0);
        $display("cmd len=%0d toggle=%0d hold=%0d -> m_data=%0d m_sat=%0d", len, toggle, hold, held, m_sat);
    endtask

    initial begin
        rst = 1'b1; pe_inj = 1'b0;
        cmd_valid = 1'b0; cmd_len = '0; s_valid = 1'b0; s_x = '0; s_k = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_s_ready", s_ready, 0);
        check_eq("rst_pe_enable", pe_enable, 0);
        check_eq("rst_pe_x", pe_x, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_data", m_data, 0);
        check_eq("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Stray PE result in IDLE: flagged, discarded, sticky.
        pe_inj = 1'b1;
        tick();
        pe_inj = 1'b0;
        check_eq("err_set_idle", err, 1);
        check_eq("idle_after_stray", cmd_ready, 1);
        repeat (3) tick();
        check_eq("err_held", err, 1);
        $display("stray pe_valid in IDLE -> err=%0d", err);

        run_cmd(1, 1'b0, 32'h03020107, 32'h01030309, 1'b0, 0, 3 + $clog2(C));
        run_cmd(3, 1'b0, 32'h03020107, 32'h01030309, 1'b1, 0, -1);
        run_cmd(0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
        run_cmd(2, 1'b0, 32'h80808080, 32'h80808080, 1'b0, 0, -1);
        run_cmd(1, 1'b0, 32'h03020107, 32'h01030309, 1'b0, 5, -1);
        run_cmd(MAX_CHUNKS, 1'b1, 32'h0, 32'h0, 1'b0, 0, -1);
        run_cmd(5, 1'b1, 32'h0, 32'h0, 1'b1, 2, -1);
        run_cmd(2, 1'b0, 32'h7F7F7F7F, 32'h80808080, 1'b0, 0, -1);
        check_eq("err_sticky", err, 1);

        // Reset in the middle of a stream.
        cmd_valid = 1'b1; cmd_len = W_LEN'(4);
        tick();
        cmd_valid = 1'b0;
        s_x = 32'h01020304; s_k = 32'h05060708; s_valid = 1'b1;
        repeat (2) tick();
        s_valid = 1'b0;
        check_eq("pre_rst_pe_enable", pe_enable, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_cmd_ready", cmd_ready, 1);
        check_eq("mid_rst_s_ready", s_ready, 0);
        check_eq("mid_rst_pe_enable", pe_enable, 0);
        check_eq("mid_rst_pe_x", pe_x, 0);
        check_eq("mid_rst_pe_k", pe_k, 0);
        check_eq("mid_rst_m_valid", m_valid, 0);
        check_eq("mid_rst_m_data", m_data, 0);
        check_eq("mid_rst_m_sat", m_sat, 0);
        check_eq("mid_rst_err", err, 0);
        $display("reset mid-STREAM -> cmd_ready=%0d err=%0d", cmd_ready, err);
        tick();
        rst = 1'b0;
        tick();

        run_cmd(2, 1'b0, 32'h03020107, 32'h01030309, 1'b0, 0, -1);
        check_eq("err_clear_after_rst", err, 0);
        check_eq("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
